// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-4 FFT datapath.
// Used by the output reorder buffer and its bank RAM.
package fft_pkg;

  localparam int OUT_WIDTH   = 27;
  localparam int LABEL_WIDTH = 11;
  localparam int LANES       = 4;
  localparam int LANE_BITS   = 2;

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] r;
    logic signed [OUT_WIDTH-1:0] i;
  } cplx_t;

endpackage

// File: rtl/fft4_bank_ram.sv
// One ping-pong bank: four lanes written together by label,
// read one word at a time by {lane, label}.
module fft4_bank_ram
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = OUT_WIDTH,
  parameter int ADDR_WIDTH = LABEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [LANES*2*DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH+1:0]        raddr,
  output logic [2*DATA_WIDTH-1:0]      rdata
);

  localparam int WW    = 2 * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WW-1:0] mem [LANES*DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < LANES; j++) begin
        mem[{LANE_BITS'(j), waddr}] <= wdata[j*WW +: WW];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft4_output_reorder.sv
// Ping-pong reorder buffer: groups of four lane results in,
// natural-order samples out over valid/ready.
module fft4_output_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = OUT_WIDTH,
  parameter int ADDR_WIDTH = LABEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [ADDR_WIDTH-1:0]        in_index,
  input  logic signed [DATA_WIDTH-1:0] in_y0_r,
  input  logic signed [DATA_WIDTH-1:0] in_y0_i,
  input  logic signed [DATA_WIDTH-1:0] in_y1_r,
  input  logic signed [DATA_WIDTH-1:0] in_y1_i,
  input  logic signed [DATA_WIDTH-1:0] in_y2_r,
  input  logic signed [DATA_WIDTH-1:0] in_y2_i,
  input  logic signed [DATA_WIDTH-1:0] in_y3_r,
  input  logic signed [DATA_WIDTH-1:0] in_y3_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_r,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic [ADDR_WIDTH+1:0]        out_k,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int WW    = 2 * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  wbank;
  logic                  rbank;
  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  // Extra MSB marks "whole frame loaded" until the release.
  logic [ADDR_WIDTH+2:0] rd_cnt;

  logic release_hs;
  logic wr_ok;
  logic wr_en;
  logic wr_last;
  logic remain;
  logic load;

  logic [LANES*WW-1:0] wdata;
  logic [WW-1:0]       rdata0;
  logic [WW-1:0]       rdata1;
  logic [WW-1:0]       rd_word;

  assign release_hs = out_valid && out_ready && out_last;
  assign wr_ok   = !full[wbank] || (release_hs && (rbank == wbank));
  assign wr_en   = in_valid && wr_ok;
  assign wr_last = wr_en && (wr_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign remain  = !rd_cnt[ADDR_WIDTH+2];
  assign load    = (!out_valid || out_ready) && full[rbank] && remain;

  assign wdata = {in_y3_r, in_y3_i, in_y2_r, in_y2_i,
                  in_y1_r, in_y1_i, in_y0_r, in_y0_i};

  fft4_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wbank),
    .waddr (in_index),
    .wdata (wdata),
    .raddr (rd_cnt[ADDR_WIDTH+1:0]),
    .rdata (rdata0)
  );

  fft4_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en && wbank),
    .waddr (in_index),
    .wdata (wdata),
    .raddr (rd_cnt[ADDR_WIDTH+1:0]),
    .rdata (rdata1)
  );

  assign rd_word = rbank ? rdata1 : rdata0;

  // Release first so a bank refilled on the same edge stays full.
  always_comb begin
    full_nxt = full;
    if (release_hs) full_nxt[rbank] = 1'b0;
    if (wr_last)    full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      full       <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_i      <= '0;
      out_k      <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      full       <= full_nxt;
      frame_done <= wr_last;
      if (in_valid && !wr_ok) overflow <= 1'b1;

      if (wr_en) begin
        if (wr_last) begin
          wr_cnt <= '0;
          wbank  <= ~wbank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (release_hs) begin
        rbank  <= ~rbank;
        rd_cnt <= '0;
      end else if (load) begin
        rd_cnt <= rd_cnt + 1'b1;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_r     <= rd_word[WW-1 -: DATA_WIDTH];
        out_i     <= rd_word[DATA_WIDTH-1:0];
        out_k     <= rd_cnt[ADDR_WIDTH+1:0];
        out_last  <= (rd_cnt[ADDR_WIDTH+1:0] == {(ADDR_WIDTH+2){1'b1}});
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft4_output_reorder.sv
// Scoreboard bench for fft4_output_reorder with a 16-sample frame.
module tb_fft4_output_reorder;

  localparam int DW = 27;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_index = '0;
  logic [DW-1:0] y0r = '0, y0i = '0, y1r = '0, y1i = '0;
  logic [DW-1:0] y2r = '0, y2i = '0, y3r = '0, y3i = '0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [DW-1:0] out_r, out_i;
  logic [AW+1:0] out_k;
  logic          out_last, frame_done, overflow;

  fft4_output_reorder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_index   (in_index),
    .in_y0_r    (y0r),
    .in_y0_i    (y0i),
    .in_y1_r    (y1r),
    .in_y1_i    (y1i),
    .in_y2_r    (y2r),
    .in_y2_i    (y2i),
    .in_y3_r    (y3r),
    .in_y3_i    (y3i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_i      (out_i),
    .out_k      (out_k),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic [AW+1:0] k;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  int fd_cnt = 0;
  int fd_exp = 0;
  int gap = -1;
  int gap_cnt = 0;
  bit gap_on = 0;
  bit hold_v = 0;
  logic [DW-1:0] h_r, h_i;
  logic [AW+1:0] h_k;
  logic          h_last;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [DW-1:0] val(int seed, int j, int l);
    return DW'(seed + 4*j + l);
  endfunction

  task automatic set_group(input int label, input int seed);
    in_valid = 1'b1;
    in_index = AW'(label);
    y0r = val(seed, 0, label); y0i = -val(seed, 0, label);
    y1r = val(seed, 1, label); y1i = -val(seed, 1, label);
    y2r = val(seed, 2, label); y2i = -val(seed, 2, label);
    y3r = val(seed, 3, label); y3i = -val(seed, 3, label);
  endtask

  task automatic push_frame(input int seed);
    exp_t e;
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 4; l++) begin
        e.r = val(seed, j, l);
        e.i = -val(seed, j, l);
        e.k = (AW+2)'(4*j + l);
        e.last = (j == 3 && l == 3);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input int labels[4], input int seed,
                            input bit push);
    for (int g = 0; g < 4; g++) begin
      set_group(labels[g], seed);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (push) begin
      push_frame(seed);
      fd_exp++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, " drain"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, " frame_done"}, fd_cnt, fd_exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_r", out_r, 0);
    check("rst out_i", out_i, 0);
    check("rst out_k", out_k, 0);
    check("rst out_last", out_last, 0);
    check("rst frame_done", frame_done, 0);
    check("rst overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
      gap_on = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (hold_v) begin
        check("stall valid", out_valid, 1);
        check("stall r", out_r, h_r);
        check("stall k", out_k, h_k);
        check("stall last", out_last, h_last);
        check("stall i", out_i, h_i);
      end
      if (gap_on && out_valid) begin
        gap = gap_cnt;
        gap_on = 0;
      end else if (gap_on) begin
        gap_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL spurious output: got k=%0d expected none", out_k);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_r", out_r, e.r);
          check("out_i", out_i, e.i);
          check("out_k", out_k, e.k);
          check("out_last", out_last, e.last);
          if (e.last) begin
            gap_on = 1;
            gap_cnt = 0;
          end
        end
      end
      hold_v = out_valid && !out_ready;
      h_r = out_r;
      h_i = out_i;
      h_k = out_k;
      h_last = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit [3:0] pat;
    int n;
    pat = 4'b1001;
    #3 rst_n = 1'b0;
    #1;
    check("init out_valid", out_valid, 0);
    check("init overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: in-order labels
    send_frame('{0, 1, 2, 3}, 0, 1);
    drain("t1");

    // 2: scrambled labels, same data
    send_frame('{3, 0, 2, 1}, 0, 1);
    drain("t2");

    // 3: ready pattern 1,0,0,1
    out_ready = 1'b0;
    send_frame('{1, 3, 0, 2}, 100, 1);
    for (int c = 0; c < 80; c++) begin
      out_ready = pat[c % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("t3");

    // 4: three frames back to back
    check("t4 overflow pre", overflow, 0);
    send_frame('{0, 1, 2, 3}, 200, 1);
    send_frame('{0, 1, 2, 3}, 300, 1);
    send_frame('{0, 1, 2, 3}, 400, 0);
    check("t4 overflow set", overflow, 1);
    drain("t4");
    check("t4 overflow sticky", overflow, 1);

    // 5: one-cycle bubble between frames
    do_reset();
    gap = -1;
    send_frame('{0, 1, 2, 3}, 500, 1);
    send_frame('{2, 1, 0, 3}, 600, 1);
    drain("t5");
    check("t5 bubble", gap, 1);

    // 6: reset with a partial frame pending
    send_frame('{0, 1, 2, 3}, 700, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6 stream start", out_valid, 1);
    set_group(0, 900);
    @(posedge clk); #1;
    set_group(1, 900);
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_reset();
    fd_cnt = 0;
    fd_exp = 0;
    send_frame('{2, 3, 0, 1}, 800, 1);
    drain("t6");
    check("t6 overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
